cnt_seq_chk: RTL and testbench

- Receive-side checker for the free-running wrap counter stream produced by the team's counter generator. The generator counts 0..CNT_MAX and wraps to 0.
- Samples the counter value on valid beats, acquires lock on the sequence and tracks the expected next value with a flywheel.
- Flags and counts sequence errors, and declares loss of lock after repeated mismatches.
- Sits at the consumer end of the counter bus, in test benches and on-chip link checks.

---
 rtl/cnt_seq_chk.sv | 149 ++++++++++++++
 tb/tb_cnt_seq_chk.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cnt_seq_chk.sv
// Receive-side checker for a 0..CNT_MAX wrap counter stream: acquires lock, flywheels, flags errors.
// Latency: all outputs registered, valid one cycle after the sampled beat. No backpressure: din_vld=0 simply freezes state.
// Optional macro CNT_SEQ_CHK_CLR_EN adds a synchronous clr input for err_cnt.
module cnt_seq_chk #(
    parameter int DATA_W    = 8,
    parameter int CNT_MAX   = 8,
    parameter int LOCK_N    = 4,
    parameter int UNLOCK_N  = 3,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
`ifdef CNT_SEQ_CHK_CLR_EN
    input  logic                 clr,
`endif
    input  logic [DATA_W-1:0]    din,
    input  logic                 din_vld,
    output logic                 locked,
    output logic                 err,
    output logic                 wrap,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    localparam int RUN_W = $clog2(LOCK_N + 1);
    localparam int BAD_W = $clog2(UNLOCK_N + 1);
    localparam logic [DATA_W-1:0] MAX_V = DATA_W'(CNT_MAX);

    typedef enum logic [1:0] {HUNT, ACQ, LOCK, SLIP} state_t;

    state_t             state;
    logic [DATA_W-1:0]  exp;
    logic [RUN_W-1:0]   run;
    logic [BAD_W-1:0]   bad;

    logic               in_range;
    logic               match;
    logic               err_hit;
    logic               clr_q;
    logic [RUN_W-1:0]   run_inc;
    logic [BAD_W-1:0]   bad_inc;

    function automatic logic [DATA_W-1:0] nxt(input logic [DATA_W-1:0] x);
        return (x == MAX_V) ? '0 : x + DATA_W'(1);
    endfunction

`ifdef CNT_SEQ_CHK_CLR_EN
    assign clr_q = clr;
`else
    assign clr_q = 1'b0;
`endif

    // exp always holds an in-range value, so an out-of-range din can never match.
    always_comb begin
        in_range = (din <= MAX_V);
        match    = (din == exp);
        run_inc  = run + RUN_W'(1);
        bad_inc  = bad + BAD_W'(1);
        err_hit  = din_vld && ((state == LOCK) || (state == SLIP)) && !match;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= HUNT;
            exp    <= '0;
            run    <= '0;
            bad    <= '0;
            locked <= 1'b0;
            err    <= 1'b0;
            wrap   <= 1'b0;
        end else begin
            err  <= 1'b0;
            wrap <= 1'b0;
            if (din_vld) begin
                case (state)
                    HUNT, ACQ: begin
                        if ((state == ACQ) && match) begin
                            run <= run_inc;
                            exp <= nxt(exp);
                            if (run_inc == RUN_W'(LOCK_N)) begin
                                state  <= LOCK;
                                locked <= 1'b1;
                                bad    <= '0;
                            end
                        end else if (in_range) begin
                            // Re-seed the run from this beat.
                            run <= RUN_W'(1);
                            exp <= nxt(din);
                            bad <= '0;
                            if (LOCK_N == 1) begin
                                state  <= LOCK;
                                locked <= 1'b1;
                            end else begin
                                state  <= ACQ;
                            end
                        end else begin
                            run   <= '0;
                            state <= HUNT;
                        end
                    end
                    LOCK: begin
                        exp <= nxt(exp);
                        if (match) begin
                            wrap <= (din == '0);
                        end else begin
                            err <= 1'b1;
                            bad <= BAD_W'(1);
                            if (UNLOCK_N == 1) begin
                                state  <= HUNT;
                                locked <= 1'b0;
                                run    <= '0;
                            end else begin
                                state  <= SLIP;
                            end
                        end
                    end
                    SLIP: begin
                        exp <= nxt(exp);
                        if (match) begin
                            bad   <= '0;
                            state <= LOCK;
                        end else begin
                            err <= 1'b1;
                            if (bad_inc == BAD_W'(UNLOCK_N)) begin
                                state  <= HUNT;
                                locked <= 1'b0;
                                run    <= '0;
                                bad    <= '0;
                            end else begin
                                bad    <= bad_inc;
                            end
                        end
                    end
                endcase
            end
        end
    end

    // Clear has priority over a same-cycle increment; the count sticks at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt <= '0;
        end else if (clr_q) begin
            err_cnt <= '0;
        end else if (err_hit && (err_cnt != '1)) begin
            err_cnt <= err_cnt + ERR_CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_cnt_seq_chk.sv
// Bench for cnt_seq_chk: directed beat sequences, a rule-level reference model and literal spot checks.
module tb_cnt_seq_chk;

    localparam int DATA_W    = 8;
    localparam int CNT_MAX   = 8;
    localparam int LOCK_N    = 4;
    localparam int UNLOCK_N  = 3;
    localparam int ECW       = 2;
    localparam int CNT_SAT   = (1 << ECW) - 1;

    logic              clk = 1'b0;
    logic              rst;
    logic [DATA_W-1:0] din;
    logic              din_vld;
    logic              locked;
    logic              err;
    logic              wrap;
    logic [ECW-1:0]    err_cnt;
`ifdef CNT_SEQ_CHK_CLR_EN
    logic              clr;
`endif

    int tests = 0;
    int fails = 0;
    int wrap_seen = 0;
    bit cmp_on = 0;

    cnt_seq_chk #(
        .DATA_W(DATA_W), .CNT_MAX(CNT_MAX), .LOCK_N(LOCK_N),
        .UNLOCK_N(UNLOCK_N), .ERR_CNT_W(ECW)
    ) dut (
        .clk(clk),
        .rst(rst),
`ifdef CNT_SEQ_CHK_CLR_EN
        .clr(clr),
`endif
        .din(din),
        .din_vld(din_vld),
        .locked(locked),
        .err(err),
        .wrap(wrap),
        .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        tests++;
        if (act !== want) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, want, $time);
        end
    endtask

    // Reference model: "synced" flag, a run of consecutive in-sequence beats while
    // not synced, and a count of consecutive misses while synced.
    bit m_sync;
    int m_exp, m_streak, m_miss;
    bit e_err, e_wrap;
    int e_cnt;

    function automatic int mnext(input int x);
        return (x == CNT_MAX) ? 0 : x + 1;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_sync = 0; m_exp = 0; m_streak = 0; m_miss = 0;
            e_err = 0; e_wrap = 0; e_cnt = 0;
        end else begin
            e_err = 0;
            e_wrap = 0;
            if (din_vld) begin
                int d;
                d = int'(din);
                if (!m_sync) begin
                    if (m_streak > 0 && d == m_exp) begin
                        m_streak++;
                        m_exp = mnext(m_exp);
                    end else if (d <= CNT_MAX) begin
                        m_streak = 1;
                        m_exp = mnext(d);
                    end else begin
                        m_streak = 0;
                    end
                    if (m_streak >= LOCK_N) begin
                        m_sync = 1;
                        m_miss = 0;
                    end
                end else begin
                    if (d == m_exp) begin
                        e_wrap = (m_miss == 0) && (d == 0);
                        m_miss = 0;
                    end else begin
                        e_err = 1;
                        if (e_cnt < CNT_SAT) e_cnt++;
                        m_miss++;
                        if (m_miss >= UNLOCK_N) begin
                            m_sync = 0;
                            m_streak = 0;
                            m_miss = 0;
                        end
                    end
                    m_exp = mnext(m_exp);
                end
            end
`ifdef CNT_SEQ_CHK_CLR_EN
            if (clr) e_cnt = 0;
`endif
        end
    end

    always @(negedge clk) begin
        if (cmp_on) begin
            chk("model_locked", locked, m_sync);
            chk("model_err", err, e_err);
            chk("model_wrap", wrap, e_wrap);
            chk("model_err_cnt", err_cnt, e_cnt);
            if (wrap === 1'b1) wrap_seen++;
        end
    end

    task automatic beat(input int d);
        din = 8'(d);
        din_vld = 1'b1;
        @(negedge clk);
        din_vld = 1'b0;
    endtask

    task automatic gap(input int n);
        din_vld = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        #2;
        rst = 1'b1;
        #1;
        chk("rst_locked", locked, 0);
        chk("rst_err", err, 0);
        chk("rst_wrap", wrap, 0);
        chk("rst_err_cnt", err_cnt, 0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0;
        int goods[5];
        rst = 1'b1;
        din = '0;
        din_vld = 1'b0;
`ifdef CNT_SEQ_CHK_CLR_EN
        clr = 1'b0;
`endif
        repeat (3) @(negedge clk);
        chk("init_locked", locked, 0);
        chk("init_err_cnt", err_cnt, 0);
        rst = 1'b0;
        cmp_on = 1;
        gap(2);

        // Out-of-range beat does not seed; 3,4,5,6 locks right after 6.
        beat(255);
        beat(3); beat(4); beat(5);
        chk("acq_not_yet", locked, 0);
        beat(6);
        chk("acq_locked", locked, 1);
        chk("acq_err_cnt", err_cnt, 0);

        // Re-seed on mismatch during acquisition.
        do_reset();
        gap(2);
        chk("post_rst_locked", locked, 0);
        beat(3); beat(4); beat(7); beat(8); beat(0);
        chk("reseed_not_yet", locked, 0);
        beat(1);
        chk("reseed_locked", locked, 1);
        beat(2);

        // Wrap with gaps of 2 idle cycles between beats.
        beat(3); beat(4); beat(5); beat(6);
        w0 = wrap_seen;
        beat(7); gap(2);
        beat(8); gap(2);
        beat(0);
        chk("wrap_pulse", wrap, 1);
        gap(2);
        chk("wrap_locked_gap", locked, 1);
        beat(1);
        chk("wrap_count", wrap_seen - w0, 1);
        chk("wrap_err_cnt", err_cnt, 0);

        // Single glitch: 2,3,9,5,6.
        beat(2); beat(3); beat(9);
        chk("glitch_err", err, 1);
        chk("glitch_err_cnt", err_cnt, 1);
        chk("glitch_locked", locked, 1);
        beat(5);
        chk("glitch_recover_err", err, 0);
        beat(6);
        chk("glitch_locked_after", locked, 1);

        // Mid-operation reset, then loss of lock.
        do_reset();
        beat(0); beat(1); beat(2); beat(3);
        chk("relock", locked, 1);
        beat(255); beat(255);
        chk("loss_still_locked", locked, 1);
        beat(255);
        chk("loss_err", err, 1);
        chk("loss_err_cnt", err_cnt, 3);
        chk("loss_unlocked", locked, 0);
        beat(0); beat(1); beat(2); beat(3);
        chk("loss_relock", locked, 1);

        // Saturation: five isolated glitches, good beat after each.
        do_reset();
        beat(0); beat(1); beat(2); beat(3);
        goods = '{5, 7, 0, 2, 4};
        for (int i = 0; i < 5; i++) begin
            beat(9);
            chk("sat_err_cnt", err_cnt, (i < 3) ? i + 1 : 3);
            beat(goods[i]);
            chk("sat_no_wrap_in_slip", wrap, 0);
        end
        chk("sat_locked", locked, 1);

`ifdef CNT_SEQ_CHK_CLR_EN
        // Clear coincident with an increment wins.
        clr = 1'b1;
        beat(9);
        clr = 1'b0;
        chk("clr_err", err, 1);
        chk("clr_err_cnt", err_cnt, 0);
        beat(6);
        beat(9);
        chk("clr_then_inc", err_cnt, 1);
`endif

        gap(3);
        cmp_on = 0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
